// File: rtl/lock_code_sender_if.sv
// rtl/lock_code_sender_if.sv - request/lock-side signal bundle for lock_code_sender
interface lock_code_sender_if #(
  parameter int CODE_LEN = 5
);
  logic                start_in;
  logic                sweep_in;
  logic [CODE_LEN-1:0] code_in;
  logic                opened_in;
  logic                lock_rst_out;
  logic                b0_out;
  logic                b1_out;
  logic                busy_out;
  logic                done_out;
  logic                found_out;
  logic [CODE_LEN-1:0] code_out;

  modport master (
    output start_in, sweep_in, code_in, opened_in,
    input  lock_rst_out, b0_out, b1_out, busy_out, done_out, found_out, code_out
  );

  modport slave (
    input  start_in, sweep_in, code_in, opened_in,
    output lock_rst_out, b0_out, b1_out, busy_out, done_out, found_out, code_out
  );
endinterface

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - serialises a code word into lock button presses, optional sweep
module lock_code_sender #(
  parameter int CODE_LEN     = 5,
  parameter int RST_CYCLES   = 1,
  parameter int GAP_CYCLES   = 1,
  parameter int PRESS_CYCLES = 1,
  parameter int CHECK_CYCLES = 2
) (
  input logic               clk,
  input logic               reset_in,
  lock_code_sender_if.slave bus
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LRST,
    S_GAP,
    S_PRESS,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CODE_LEN-1:0] code_q, code_n;
  logic                sweep_q, sweep_n;
  logic                success_q, success_n;
  logic                found_q, found_n;
  logic                lock_rst_q, lock_rst_n;
  logic                b0_q, b0_n;
  logic                b1_q, b1_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                hit;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      code_q     <= '0;
      sweep_q    <= 1'b0;
      success_q  <= 1'b0;
      found_q    <= 1'b0;
      lock_rst_q <= 1'b0;
      b0_q       <= 1'b0;
      b1_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      code_q     <= code_n;
      sweep_q    <= sweep_n;
      success_q  <= success_n;
      found_q    <= found_n;
      lock_rst_q <= lock_rst_n;
      b0_q       <= b0_n;
      b1_q       <= b1_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  // cnt counts cycles spent in the current timed state; each timed state exits on its last cycle
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    code_n    = code_q;
    sweep_n   = sweep_q;
    success_n = success_q;
    found_n   = found_q;
    hit       = success_q | bus.opened_in;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (bus.start_in) begin
          code_n    = bus.code_in;
          sweep_n   = bus.sweep_in;
          found_n   = 1'b0;
          success_n = 1'b0;
          idx_n     = IDX_W'(CODE_LEN - 1);
          state_n   = S_LRST;
        end
      end
      S_LRST: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_PRESS;
        end
      end
      S_PRESS: begin
        if (cnt == CNT_W'(PRESS_CYCLES - 1)) begin
          cnt_n = '0;
          if (idx == '0) begin
            state_n = S_CHECK;
          end else begin
            idx_n   = idx - IDX_W'(1);
            state_n = S_GAP;
          end
        end
      end
      S_CHECK: begin
        if (bus.opened_in) success_n = 1'b1;
        if (cnt == CNT_W'(CHECK_CYCLES - 1)) begin
          cnt_n = '0;
          // all-ones ends a failed sweep: the code register never wraps
          if (hit || !sweep_q || (&code_q)) begin
            found_n = hit;
            state_n = S_DONE;
          end else begin
            state_n = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        cnt_n     = '0;
        code_n    = code_q + CODE_LEN'(1);
        success_n = 1'b0;
        idx_n     = IDX_W'(CODE_LEN - 1);
        state_n   = S_LRST;
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they appear registered in the state they belong to
  always_comb begin
    lock_rst_n = (state_n == S_LRST);
    busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n     = (state_n == S_DONE);
    b1_n       = (state_n == S_PRESS) &&  code_n[idx_n];
    b0_n       = (state_n == S_PRESS) && !code_n[idx_n];
  end

  assign bus.lock_rst_out = lock_rst_q;
  assign bus.b0_out       = b0_q;
  assign bus.b1_out       = b1_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;
  assign bus.found_out    = found_q;
  assign bus.code_out     = code_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// tb/tb_lock_code_sender.sv - table-driven scoreboard bench for lock_code_sender
module tb_lock_code_sender;

  logic clk = 1'b0;
  logic reset_in;
  always #5 clk = ~clk;

  lock_code_sender_if #(.CODE_LEN(5)) bus ();

  lock_code_sender #(.CODE_LEN(5)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  typedef struct {
    logic       sweep;
    logic [4:0] code;
    logic [4:0] target;
    logic       never;
    logic       exp_found;
    logic [4:0] exp_code;
    int         exp_cycles;
    int         exp_attempts;
  } vec_t;

  typedef struct {
    logic       found;
    logic [4:0] code;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   lrst_rises = 0;
  int   both_hi = 0;
  int   dones = 0;
  logic prev_lrst = 1'b0;

  // lock model: reset clears it, every button-active cycle shifts in one bit, opens on the 5th matching press
  logic [4:0] lk_target = 5'd0;
  logic       lk_never = 1'b0;
  logic [4:0] lk_sh = 5'd0;
  logic [3:0] lk_n = 4'd0;
  logic       lk_open = 1'b0;
  assign bus.opened_in = lk_open;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.lock_rst_out) begin
      lk_sh   <= 5'd0;
      lk_n    <= 4'd0;
      lk_open <= 1'b0;
    end else if (bus.b0_out || bus.b1_out) begin
      lk_sh   <= {lk_sh[3:0], bus.b1_out};
      lk_n    <= lk_n + 4'd1;
      lk_open <= (lk_n == 4'd4) && !lk_never && ({lk_sh[3:0], bus.b1_out} == lk_target);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.lock_rst_out && !prev_lrst) lrst_rises++;
    prev_lrst = bus.lock_rst_out;
    if (bus.b0_out && bus.b1_out) both_hi++;
    if (bus.done_out) begin
      dones++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("found_at_done", int'(bus.found_out), int'(e.found));
        check("code_at_done", int'(bus.code_out), int'(e.code));
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_lock_rst"}, int'(bus.lock_rst_out), 0);
    check({nm, "_b0"}, int'(bus.b0_out), 0);
    check({nm, "_b1"}, int'(bus.b1_out), 0);
    check({nm, "_busy"}, int'(bus.busy_out), 0);
    check({nm, "_done"}, int'(bus.done_out), 0);
    check({nm, "_found"}, int'(bus.found_out), 0);
    check({nm, "_code"}, int'(bus.code_out), 0);
  endtask

  task automatic run_vec(input vec_t v, input bit hold);
    exp_t e;
    int   s;
    int   n;
    int   r0;
    r0 = lrst_rises;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.sweep_in = v.sweep;
    bus.code_in  = v.code;
    lk_target    = v.target;
    lk_never     = v.never;
    s            = cyc;
    e.found      = v.exp_found;
    e.code       = v.exp_code;
    e.done_cyc   = s + v.exp_cycles;
    sb.push_back(e);
    @(negedge clk);
    check("lock_rst_first_cycle", int'(bus.lock_rst_out), 1);
    check("busy_first_cycle", int'(bus.busy_out), 1);
    if (!hold) bus.start_in = 1'b0;
    n = 0;
    while (!bus.done_out && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", int'(bus.done_out), 1);
    if (!bus.done_out) sb.delete();
    check("busy_in_done", int'(bus.busy_out), 0);
    @(negedge clk);
    bus.start_in = 1'b0;
    check("busy_after_done", int'(bus.busy_out), 0);
    check("done_one_cycle", int'(bus.done_out), 0);
    check("found_held", int'(bus.found_out), int'(v.exp_found));
    check("code_held", int'(bus.code_out), int'(v.exp_code));
    check("lock_resets", lrst_rises - r0, v.exp_attempts);
    check("presses_per_attempt", int'(lk_n), 5);
    check("last_pressed_code", int'(lk_sh), int'(v.exp_code));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   d0;
    int   n;
    vecs[0] = '{1'b0, 5'b01101, 5'b01101, 1'b0, 1'b1, 5'b01101, 14, 1};
    vecs[1] = '{1'b0, 5'b00000, 5'b01101, 1'b0, 1'b0, 5'b00000, 14, 1};
    vecs[2] = '{1'b0, 5'b11111, 5'b11111, 1'b0, 1'b1, 5'b11111, 14, 1};
    vecs[3] = '{1'b0, 5'b10010, 5'b01101, 1'b0, 1'b0, 5'b10010, 14, 1};
    vecs[4] = '{1'b1, 5'd0,     5'd13,    1'b0, 1'b1, 5'd13,    196, 14};
    vecs[5] = '{1'b1, 5'd0,     5'd0,     1'b1, 1'b0, 5'd31,    448, 32};
    vecs[6] = '{1'b1, 5'd30,    5'd31,    1'b0, 1'b1, 5'd31,    28, 2};
    vecs[7] = '{1'b1, 5'd31,    5'd0,     1'b1, 1'b0, 5'd31,    14, 1};
    vecs[8] = '{1'b1, 5'd13,    5'd13,    1'b0, 1'b1, 5'd13,    14, 1};

    reset_in     = 1'b1;
    bus.start_in = 1'b0;
    bus.sweep_in = 1'b0;
    bus.code_in  = 5'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset_in = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    // reset during the third press of a single attempt
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.sweep_in = 1'b0;
    bus.code_in  = 5'b01101;
    lk_target    = 5'b01101;
    lk_never     = 1'b0;
    @(negedge clk);
    bus.start_in = 1'b0;
    n = 0;
    while (!((bus.b0_out || bus.b1_out) && lk_n == 4'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("third_press_reached", int'(lk_n), 2);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check_all_zero("mid_op_reset");
    d0 = dones;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", dones - d0, 0);
    check("idle_after_reset", int'(bus.busy_out), 0);
    run_vec(vecs[0], 1'b0);

    // start held high through the whole attempt
    run_vec(vecs[2], 1'b1);
    d0 = dones;
    repeat (20) @(negedge clk);
    check("held_start_no_rerun", dones - d0, 0);

    // reset wins over a simultaneous start
    @(negedge clk);
    bus.start_in = 1'b1;
    reset_in     = 1'b1;
    bus.sweep_in = 1'b0;
    bus.code_in  = 5'b01101;
    @(negedge clk);
    bus.start_in = 1'b0;
    reset_in     = 1'b0;
    check_all_zero("start_with_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stay_idle_busy", int'(bus.busy_out), 0);
    end

    check("both_buttons_high_cycles", both_hi, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmit-side companion to the two-button sequence lock (fsm_lock).
- Converts an N-bit code word into the lock's button protocol: lock reset pulse, then one press per bit, MSB first, with all-released gaps between presses.
- Samples the lock's open indication and reports the result.
- Optional sweep mode steps through codes until the lock opens. Used as the on-board stimulus engine and as a reusable lock driver.

Parameters:
- CODE_LEN, 5: bits per code word, i.e. presses per attempt.
- RST_CYCLES, 1: cycles `lock_rst_out` is held high at the start of each attempt.
- GAP_CYCLES, 1: cycles with both buttons released before each press.
- PRESS_CYCLES, 1: cycles each button is held.
- CHECK_CYCLES, 2: cycles `opened_in` is sampled after the last press.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- start_in  in  1  begin an operation; accepted only in IDLE.
- sweep_in  in  1  sampled with `start_in`. 0 = single attempt; 1 = sweep upward from `code_in`.
- code_in  in  CODE_LEN  code to send, or sweep start value; sampled with `start_in`.
- opened_in  in  1  lock's `out`.
- lock_rst_out  out  1  drives the lock's `reset_in`.
- b0_out  out  1  button 0 (sends a 0 bit).
- b1_out  out  1  button 1 (sends a 1 bit).
- busy_out  out  1  high while an operation is in progress.
- done_out  out  1  one-cycle pulse at the end of an operation.
- found_out  out  1  1 if the lock opened; valid from `done_out`, held until the next accepted start.
- code_out  out  CODE_LEN  code of the current or last attempt; held after done.

Behaviour:
- Reset:
  - `reset_in` high at an edge forces IDLE.
  - All outputs 0; internal counters and code register cleared.
  - Reset takes effect mid-operation: every output is 0 in the cycle after the edge, and no `done_out` pulse is issued.
  - Reset has priority over a simultaneous `start_in`.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, LRST, GAP, PRESS, CHECK, NEXT, DONE.
- IDLE:
  - On `start_in` = 1, latch `code_in` into the code register and latch `sweep_in`.
  - Clear `found_out` and the bit index (index = CODE_LEN-1).
  - Go to LRST.
  - `start_in` in any other state is ignored.
- LRST: `lock_rst_out` = 1, buttons 0, for RST_CYCLES cycles, then GAP.
- GAP: both buttons 0 for GAP_CYCLES cycles, then PRESS.
- PRESS:
  - For PRESS_CYCLES cycles: `b1_out` = code[index], `b0_out` = ~code[index].
  - `b0_out` and `b1_out` are never both 1.
  - If index = 0, go to CHECK; otherwise decrement index and go to GAP.
- CHECK:
  - Buttons 0 for CHECK_CYCLES cycles.
  - If `opened_in` = 1 on any of these cycles, set the success flag.
  - `opened_in` is ignored in all other states.
- After CHECK:
  - Success, or single mode: go to DONE.
  - Sweep, failure, code = all-ones: go to DONE with `found_out` = 0. There is no wrap-around.
  - Sweep, failure, otherwise: go to NEXT.
- NEXT: one cycle; code register increments by 1; go to LRST.
- DONE:
  - One cycle: `done_out` = 1, `busy_out` = 0, `found_out` = success flag.
  - Return to IDLE.
- `busy_out` = 1 in every state except IDLE and DONE.
- `code_out` always mirrors the code register.
- Timing:
  - Attempt length A = RST_CYCLES + CODE_LEN*(GAP_CYCLES+PRESS_CYCLES) + CHECK_CYCLES; 13 at defaults.
  - With start accepted at edge k: `lock_rst_out` and `busy_out` rise in cycle k+1.
  - Single mode: `done_out` is high in cycle k+1+A.
  - Sweep over M attempts: `done_out` is high in cycle k+1+M*A+(M-1).

Test Plan:
- Single mode, code_in = 5'b01101, lock model opens on 01101 → `lock_rst_out` in cycle 1. Presses b0, b1, b1, b0, b1, each preceded by a 1-cycle gap. `done_out` pulse in cycle 14 after the start edge, `found_out` = 1, `code_out` = 01101.
- Single mode, code_in = 5'b00000, same lock model → 5 presses, all on b0. `done_out` in cycle 14, `found_out` = 0.
- Sweep from 0, lock opens on 13 → 14 attempts and 13 lock resets after the first. `done_out` at cycle 1+14*13+13 = 196, `found_out` = 1, `code_out` = 13. Checker flags any cycle with both buttons high.
- Sweep from 0, lock never opens → 32 attempts. `done_out` at cycle 1+32*13+31 = 448, `found_out` = 0, `code_out` = 31; code does not wrap.
- Assert `reset_in` during the 3rd press of a single attempt → in the next cycle all outputs are 0 and the block is in IDLE. No `done_out` pulse ever follows. A subsequent start runs a full attempt normally.
- `start_in` held high throughout an attempt, including the DONE cycle → exactly one attempt runs and the second start is ignored. Then `start_in` and `reset_in` asserted together in IDLE → the block stays IDLE and `busy_out` stays 0.
